// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - lsu_state_e : control FSM states (IDLE, ACCESS, RESP)
//   - F3_*        : RISC-V load/store funct3 encodings that the unit accepts
//   - SIZE_*      : size field of the memory dataControl bus ([1:0])
// The memory dataControl bus is funct3 passed straight through:
// bit 2 selects unsigned, and bits 1:0 give the size.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/lsu_req_check.sv
// Combinational request legality check for the load/store unit.
// Ports:
//   write_i    1  1 = store, 0 = load
//   funct3_i   3  RISC-V funct3 of the request
//   addr_lo_i  2  low address bits, used only for the alignment check
//   err_o      1  request must be answered with an error and must not reach memory
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// half access or word access is also reported as an error.
module lsu_req_check
  import lsu_pkg::*;
(
  input  logic       write_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic       err_o
);

  logic illegal;
  logic misalign;

  always_comb begin
    illegal = 1'b1;
    if (write_i) begin
      illegal = !(funct3_i inside {F3_B, F3_H, F3_W});
    end else begin
      illegal = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (funct3_i[1:0])
      SIZE_HALF: misalign = addr_lo_i[0];
      SIZE_WORD: misalign = |addr_lo_i;
      default:   misalign = 1'b0;
    endcase
`endif

    err_o = illegal | misalign;
  end

`ifndef MISALIGN_TRAP_EN
  // Without the alignment trap, the low address bits have no effect on the result.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo_i;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit. This module is the initiator side of the data-memory port.
// It accepts one load or store at a time from the core. It holds that request
// on the byte-addressed, big-endian data memory for MEM_LAT cycles. It then
// returns the load data, or the store completion, on a valid/ready response
// channel.
// Parameters: XLEN (data/address width), MEM_LAT (cycles in ACCESS, must be >= 1).
// Ports:
//   clk, rst                          clock; asynchronous active-high reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write/req_funct3/req_addr/req_wdata  request fields
//   resp_valid/resp_ready             response handshake
//   resp_rdata/resp_err               load data (0 for stores and errors); error flag
//   mem_write_enable/mem_addr/mem_write_data/mem_dataControl  memory request (0 outside ACCESS)
//   mem_read_data                     combinational read data from memory, already extended
//   busy                              high whenever the unit is not in IDLE
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are answered with resp_err and are not issued to memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic [2:0]      mem_dataControl,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            write_q, write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic req_err;
  logic in_access;
  logic last_access;

  lsu_req_check u_req_check (
    .write_i   (req_write),
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .err_o     (req_err)
  );

  assign in_access   = (state_q == ACCESS);
  assign last_access = in_access && (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_err;
          // An erroneous request skips the memory cycle and goes straight to the response.
          state_d  = req_err ? RESP : ACCESS;
          cnt_d    = CNT_W'(MEM_LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!write_q) rdata_d = mem_read_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state. The reset is asynchronous, so it aborts any access in
  // flight. Because the memory strobe below is decoded combinationally from
  // this state, the strobe drops as soon as reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request and response data. These registers have no reset; every
  // output that is driven from them is gated by the state.
  always_ff @(posedge clk) begin
    write_q  <= write_d;
    funct3_q <= funct3_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    rdata_q  <= rdata_d;
    err_q    <= err_d;
  end

  // Output decode
  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign busy             = (state_q != IDLE);
  assign resp_rdata       = resp_valid ? rdata_q : '0;
  assign resp_err         = resp_valid ? err_q : 1'b0;
  assign mem_addr         = in_access ? addr_q : '0;
  assign mem_write_data   = in_access ? wdata_q : '0;
  assign mem_dataControl  = in_access ? funct3_q : 3'b000;
  assign mem_write_enable = last_access && write_q;

endmodule
